// File: rtl/vp_key_arbiter_if.sv
// Keypad event bus between the top-level input decode, vp_key_arbiter and
// vp_keymap. The master side drives the raw events and the keymap read
// strobe. The slave side is the arbiter.
interface vp_key_arbiter_if;
  logic       ps2_stb_i;
  logic [7:0] ps2_ascii_i;
  logic       ps2_released_i;
  logic [9:0] joy_numpad_i;
  logic       rx_read_i;
  logic       rx_data_ready_o;
  logic [7:0] rx_ascii_o;
  logic       rx_released_o;
  logic       overflow_o;
  logic       timeout_o;

  modport master (
    output ps2_stb_i, ps2_ascii_i, ps2_released_i, joy_numpad_i, rx_read_i,
    input  rx_data_ready_o, rx_ascii_o, rx_released_o, overflow_o, timeout_o
  );

  modport slave (
    input  ps2_stb_i, ps2_ascii_i, ps2_released_i, joy_numpad_i, rx_read_i,
    output rx_data_ready_o, rx_ascii_o, rx_released_o, overflow_o, timeout_o
  );
endinterface

// File: rtl/vp_key_arbiter.sv
// Merges PS/2 ASCII events and gamepad digit buttons into one ordered event
// stream. Events are buffered in a small FIFO and handed to vp_keymap one at
// a time, with an idle gap after each event. A presented event that is never
// read is dropped after a timeout.
module vp_key_arbiter #(
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic            clk_i,
  input  logic            res_n_i,
  vp_key_arbiter_if.slave bus
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] CNT_SAT      = {CW{1'b1}};
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   PTR_ONE      = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } state_t;

  // ASCII code of gamepad button idx: bit0..bit8 map to '1'..'9', and bit9 maps to '0'.
  function automatic logic [7:0] digit_ascii(input logic [3:0] idx);
    return (idx == 4'd9) ? 8'h30 : (8'h31 + {4'd0, idx});
  endfunction

  // Returns {hit, index} of the lowest set bit of a button mask.
  function automatic logic [4:0] lowest_set(input logic [9:0] mask);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 9; i >= 0; i--) begin
      if (mask[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          ready_r, ready_s;
  logic          timeout_r, timeout_s;
  logic [7:0]    ascii_r;
  logic          released_r;
  logic          overflow_r;

  logic [8:0]    mem_r [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_r, rd_ptr_r;
  logic          empty_s, full_s, pop_s, room_s;

  logic [9:0]    hist_r, pend_press_r, pend_rel_r;
  logic [4:0]    press_sel_s, rel_sel_s;
  logic          ps2_valid_s;
  logic          wr_en_s, ovf_set_s;
  logic [8:0]    wr_data_s;
  logic [9:0]    clr_press_s, clr_rel_s;

  // FIFO status. The extra pointer MSB tells a full FIFO from an empty one.
  // A full FIFO still accepts a write while the head is popped.
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s   = (state_r == ST_IDLE) && !empty_s;
    room_s  = !full_s || pop_s;
  end

  // Enqueue arbitration: PS/2 first, then pending presses, then releases whose press has gone out.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_data_s   = 9'd0;
    ovf_set_s   = 1'b0;
    clr_press_s = 10'd0;
    clr_rel_s   = 10'd0;
    ps2_valid_s = bus.ps2_stb_i && (bus.ps2_ascii_i != 8'h00);
    press_sel_s = lowest_set(pend_press_r);
    rel_sel_s   = lowest_set(pend_rel_r & ~pend_press_r);
    if (ps2_valid_s) begin
      wr_en_s   = room_s;
      wr_data_s = {bus.ps2_released_i, bus.ps2_ascii_i};
      ovf_set_s = !room_s;
    end else if (press_sel_s[4]) begin
      wr_en_s     = room_s;
      wr_data_s   = {1'b0, digit_ascii(press_sel_s[3:0])};
      clr_press_s = room_s ? (10'd1 << press_sel_s[3:0]) : 10'd0;
    end else if (rel_sel_s[4]) begin
      wr_en_s   = room_s;
      wr_data_s = {1'b1, digit_ascii(rel_sel_s[3:0])};
      clr_rel_s = room_s ? (10'd1 << rel_sel_s[3:0]) : 10'd0;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 9'd0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wr_data_s;
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Joystick edge detection. A new edge wins over a same-cycle clear, so a re-press is not lost.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      hist_r       <= 10'd0;
      pend_press_r <= 10'd0;
      pend_rel_r   <= 10'd0;
    end else begin
      hist_r       <= bus.joy_numpad_i;
      pend_press_r <= (pend_press_r & ~clr_press_s) | (bus.joy_numpad_i & ~hist_r);
      pend_rel_r   <= (pend_rel_r & ~clr_rel_s) | (~bus.joy_numpad_i & hist_r);
    end
  end

  // Presentation FSM next state. The ack has priority over a timeout in the same cycle.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    ready_s   = ready_r;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          state_s = ST_PRESENT;
          cnt_s   = '0;
          ready_s = 1'b1;
        end else begin
          ready_s = 1'b0;
        end
      end
      ST_PRESENT: begin
        if (bus.rx_read_i) begin
          state_s = ST_GAP;
          cnt_s   = '0;
          ready_s = 1'b0;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_s   = ST_GAP;
          cnt_s     = '0;
          ready_s   = 1'b0;
          timeout_s = 1'b1;
        end else begin
          cnt_s = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + {{(CW-1){1'b0}}, 1'b1});
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + {{(CW-1){1'b0}}, 1'b1});
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        ready_s = 1'b0;
      end
    endcase
  end

  // FSM state, counter and registered handshake outputs.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      ready_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      ready_r   <= ready_s;
      timeout_r <= timeout_s;
    end
  end

  // Presented data is latched only when the head is popped, so it stays stable while presented.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      ascii_r    <= 8'h00;
      released_r <= 1'b0;
    end else if (pop_s) begin
      ascii_r    <= mem_r[rd_ptr_r[AW-1:0]][7:0];
      released_r <= mem_r[rd_ptr_r[AW-1:0]][8];
    end
  end

  // Sticky overflow flag. It is set only when a PS/2 event is dropped.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) overflow_r <= 1'b0;
    else if (ovf_set_s) overflow_r <= 1'b1;
  end

  assign bus.rx_data_ready_o = ready_r;
  assign bus.rx_ascii_o      = ascii_r;
  assign bus.rx_released_o   = released_r;
  assign bus.overflow_o      = overflow_r;
  assign bus.timeout_o       = timeout_r;
endmodule

// File: tb/tb_vp_key_arbiter.sv
// Testbench for vp_key_arbiter. An event-queue model predicts the outputs on every
// cycle, and directed scenarios add hand-computed literal checks.
module tb_vp_key_arbiter;
  localparam int DEPTH = 4;
  localparam int GAP   = 16;
  localparam int TMO   = 65535;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  vp_key_arbiter_if bus ();

  vp_key_arbiter #(
    .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .res_n_i(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] keytab [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                              8'h36, 8'h37, 8'h38, 8'h39, 8'h30};
  logic [8:0] m_q [$];
  int         m_phase = 0;   // 0 = waiting, 1 = showing an event, 2 = gap
  int         m_left  = 0;   // cycles left in the current phase
  logic       m_ready = 1'b0, m_to = 1'b0, m_ovf = 1'b0, m_rel = 1'b0;
  logic [7:0] m_ascii = 8'h00;
  logic [9:0] m_hist = 10'd0, m_pp = 10'd0, m_pr = 10'd0;
  logic [8:0] m_ev;
  int         m_pi, m_ri;

  function automatic int lowest(input logic [9:0] m);
    for (int i = 0; i < 10; i++) if (m[i]) return i;
    return -1;
  endfunction

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_phase = 0; m_left = 0; m_ready = 1'b0; m_to = 1'b0; m_ovf = 1'b0;
        m_ascii = 8'h00; m_rel = 1'b0; m_hist = 10'd0; m_pp = 10'd0; m_pr = 10'd0;
      end else begin
        m_to = 1'b0;
        if (m_phase == 0) begin
          if (m_q.size() > 0) begin
            m_ev = m_q.pop_front();
            m_ascii = m_ev[7:0]; m_rel = m_ev[8];
            m_ready = 1'b1; m_phase = 1; m_left = TMO;
          end
        end else if (m_phase == 1) begin
          if (bus.rx_read_i) begin
            m_ready = 1'b0; m_phase = 2; m_left = GAP;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_ready = 1'b0; m_to = 1'b1; m_phase = 2; m_left = GAP;
            end
          end
        end else begin
          m_left--;
          if (m_left == 0) m_phase = 0;
        end
        m_pi = lowest(m_pp);
        m_ri = lowest(m_pr & ~m_pp);
        if (bus.ps2_stb_i && bus.ps2_ascii_i != 8'h00) begin
          if (m_q.size() < DEPTH) m_q.push_back({bus.ps2_released_i, bus.ps2_ascii_i});
          else m_ovf = 1'b1;
        end else if (m_pi >= 0) begin
          if (m_q.size() < DEPTH) begin m_q.push_back({1'b0, keytab[m_pi]}); m_pp[m_pi] = 1'b0; end
        end else if (m_ri >= 0) begin
          if (m_q.size() < DEPTH) begin m_q.push_back({1'b1, keytab[m_ri]}); m_pr[m_ri] = 1'b0; end
        end
        for (int i = 0; i < 10; i++) begin
          if (bus.joy_numpad_i[i] && !m_hist[i]) m_pp[i] = 1'b1;
          if (!bus.joy_numpad_i[i] && m_hist[i]) m_pr[i] = 1'b1;
        end
        m_hist = bus.joy_numpad_i;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      check("outputs", {bus.rx_data_ready_o, bus.rx_ascii_o, bus.rx_released_o,
                        bus.overflow_o, bus.timeout_o},
                       {m_ready, m_ascii, m_rel, m_ovf, m_to});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] a, input logic rel);
    bus.ps2_stb_i = 1'b1; bus.ps2_ascii_i = a; bus.ps2_released_i = rel;
    tick(1);
    bus.ps2_stb_i = 1'b0; bus.ps2_ascii_i = 8'h00; bus.ps2_released_i = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.rx_data_ready_o && n < 200) begin tick(1); n++; end
    check({name, "_wait"}, {31'd0, bus.rx_data_ready_o}, 32'd1);
  endtask

  task automatic present_ack(input string name, input logic [7:0] a, input logic rel);
    wait_ready(name);
    check(name, {23'd0, bus.rx_released_o, bus.rx_ascii_o}, {23'd0, rel, a});
    bus.rx_read_i = 1'b1;
    tick(1);
    bus.rx_read_i = 1'b0;
    check({name, "_drop"}, {31'd0, bus.rx_data_ready_o}, 32'd0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int n;
    bus.ps2_stb_i = 1'b0; bus.ps2_ascii_i = 8'h00; bus.ps2_released_i = 1'b0;
    bus.joy_numpad_i = 10'd0; bus.rx_read_i = 1'b0;
    #2 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    check("reset_outputs", {20'd0, bus.rx_data_ready_o, bus.rx_ascii_o, bus.rx_released_o,
                            bus.overflow_o, bus.timeout_o}, 32'd0);
    tick(2);

    // Single event: the ready output rises one edge after the write.
    strobe(8'h35, 1'b0);
    check("lat_edge_n", {31'd0, bus.rx_data_ready_o}, 32'd0);
    tick(1);
    check("lat_edge_n1", {22'd0, bus.rx_data_ready_o, bus.rx_ascii_o, bus.rx_released_o},
          {22'd0, 1'b1, 8'h35, 1'b0});
    strobe(8'h36, 1'b0);
    check("data_stable", {23'd0, bus.rx_data_ready_o, bus.rx_ascii_o}, {23'd0, 1'b1, 8'h35});
    bus.rx_read_i = 1'b1; tick(1); bus.rx_read_i = 1'b0;
    check("ack_drop", {31'd0, bus.rx_data_ready_o}, 32'd0);
    n = 0;
    while (!bus.rx_data_ready_o && n < 100) begin n++; tick(1); end
    check("gap_len", n, 32'd17);
    present_ack("second", 8'h36, 1'b0);

    // Simultaneous PS/2 and joystick: 'a', then '3' press, then '3' release.
    tick(20);
    bus.ps2_stb_i = 1'b1; bus.ps2_ascii_i = 8'h61; bus.joy_numpad_i = 10'b00_0000_0100;
    tick(1);
    bus.ps2_stb_i = 1'b0; bus.ps2_ascii_i = 8'h00;
    present_ack("simul_a", 8'h61, 1'b0);
    bus.joy_numpad_i = 10'd0;
    present_ack("simul_3p", 8'h33, 1'b0);
    present_ack("simul_3r", 8'h33, 1'b1);

    // Fast tap on '0' while the FIFO is full.
    tick(20);
    for (int i = 0; i < 5; i++) strobe(8'h41 + 8'(i), 1'b0);
    bus.joy_numpad_i = 10'b10_0000_0000; tick(1);
    bus.joy_numpad_i = 10'd0; tick(1);
    check("tap_no_ovf", {31'd0, bus.overflow_o}, 32'd0);
    for (int i = 0; i < 5; i++) present_ack("tap_ps2", 8'h41 + 8'(i), 1'b0);
    present_ack("tap_0p", 8'h30, 1'b0);
    present_ack("tap_0r", 8'h30, 1'b1);
    check("tap_no_ovf_end", {31'd0, bus.overflow_o}, 32'd0);

    // Overflow: the sixth strobe finds the FIFO full.
    tick(20);
    for (int i = 0; i < 6; i++) strobe(8'h50 + 8'(i), 1'b0);
    check("ovf_set", {31'd0, bus.overflow_o}, 32'd1);
    for (int i = 0; i < 5; i++) present_ack("ovf_drain", 8'h50 + 8'(i), 1'b0);
    n = 0;
    for (int i = 0; i < 30; i++) begin if (bus.rx_data_ready_o) n++; tick(1); end
    check("ovf_dropped", n, 32'd0);
    check("ovf_sticky", {31'd0, bus.overflow_o}, 32'd1);

    // Timeout: the first event is never read.
    strobe(8'h71, 1'b0);
    strobe(8'h72, 1'b0);
    wait_ready("to_first");
    check("to_first", {24'd0, bus.rx_ascii_o}, {24'd0, 8'h71});
    n = 0;
    while (bus.rx_data_ready_o && n < 70000) begin n++; tick(1); end
    check("to_len", n, 32'd65535);
    check("to_pulse", {31'd0, bus.timeout_o}, 32'd1);
    tick(1);
    check("to_pulse_end", {31'd0, bus.timeout_o}, 32'd0);
    wait_ready("to_next");
    check("to_next", {24'd0, bus.rx_ascii_o}, {24'd0, 8'h72});

    // Reset in mid-presentation with one event still queued.
    strobe(8'h73, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_ready", {31'd0, bus.rx_data_ready_o}, 32'd0);
    check("async_ovf", {31'd0, bus.overflow_o}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin if (bus.rx_data_ready_o) n++; tick(1); end
    check("no_stale", n, 32'd0);
    strobe(8'h7a, 1'b0);
    present_ack("after_reset", 8'h7a, 1'b0);
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vp_key_arbiter.md
Name: vp_key_arbiter

Overview:
- Merges keypad events from two sources: the PS/2 keyboard (already translated to ASCII) and the gamepad numeric buttons (joy_numpad, 10 bits).
- Serialises the events through a small FIFO and presents them one at a time to vp_keymap using its ready/read handshake.
- Replaces the ad-hoc OR-merge in the top level, which can lose or stick keys when both sources are active.
- Sits between the input decode in the top level and vp_keymap, in the clk_sys domain.

Parameters:
FIFO_DEPTH, 4, number of event entries (power of two, >=2)
GAP_CYCLES, 16, idle cycles forced between two presented events
TIMEOUT_CYCLES, 65535, cycles without rx_read_i before the presented event is dropped

Ports:
clk_i  in  1  system clock (clk_sys)
res_n_i  in  1  asynchronous active-low reset
ps2_stb_i  in  1  one-cycle strobe: new PS/2 event
ps2_ascii_i  in  8  ASCII code of PS/2 event (0x00 = unmapped)
ps2_released_i  in  1  1 = PS/2 key release
joy_numpad_i  in  10  gamepad digit buttons, level, bit0='1' .. bit8='9', bit9='0'
rx_data_ready_o  out  1  event valid towards vp_keymap
rx_ascii_o  out  8  presented ASCII code
rx_released_o  out  1  presented event is a release
rx_read_i  in  1  vp_keymap consumed event (rx_read_o of keymap)
overflow_o  out  1  sticky: an event was dropped because the FIFO was full
timeout_o  out  1  one-cycle pulse: presented event dropped on timeout

Behaviour:
- Clock and reset: one clock, clk_i. Reset res_n_i is asynchronous, active-low.
- Reset values:
  - All outputs 0 (rx_ascii_o=0x00).
  - FIFO empty, FSM in IDLE, counters 0.
  - Joystick history register = 0, pending masks = 0.
- Joystick edge detect: each cycle, compare joy_numpad_i against the history register.
  - Rising bit i sets pend_press[i].
  - Falling bit i sets pend_rel[i].
  - History updates every cycle.
- Enqueue: at most one write per cycle, in this priority order:
  1. ps2_stb_i with ps2_ascii_i != 0 → writes {ps2_released_i, ps2_ascii_i}. Unmapped codes (0x00) are discarded silently.
  2. Lowest-index set pend_press bit → writes {0, digit}; clears that bit.
  3. Lowest-index set pend_rel bit whose pend_press bit is clear → writes {1, digit}; clears that bit. A press of the same key is always enqueued before its release.
- FIFO full on an enqueue attempt:
  - PS/2 event is dropped and overflow_o is set (sticky until reset).
  - Joystick pending bits are retained; they are not dropped and overflow_o is not set.
- A write and a pop in the same cycle while the FIFO is full both succeed.
- FSM states:
  - IDLE: if FIFO is non-empty, latch the head into rx_ascii_o/rx_released_o, pop it, assert rx_data_ready_o, go to PRESENT.
  - PRESENT: rx_data_ready_o holds 1 and the data is stable.
    - rx_read_i=1 → deassert ready, go to GAP.
    - Counter reaches TIMEOUT_CYCLES → deassert ready, pulse timeout_o, go to GAP.
    - rx_read_i on the same cycle as the timeout counts as an ack; no timeout pulse.
  - GAP: ready=0; count GAP_CYCLES cycles, then go to IDLE. rx_read_i is ignored here.
- Latency: strobe sampled at edge N → FIFO entry written at N → ready high after edge N+1 (if IDLE and FIFO was empty).
- rx_ascii_o/rx_released_o change only on IDLE→PRESENT.
- Reset mid-operation: ready drops immediately (asynchronous). FIFO and pending events are lost. A key physically held on a joystick through reset is re-seen as a press, because history is 0.
- Counters must saturate, not wrap. FIFO pointers are log2(FIFO_DEPTH)+1 bits wide, with a wrap bit for full/empty.

Test Plan:
- Single PS/2 event: strobe ascii=0x35, released=0 → ready high 2 cycles later with 0x35/0; rx_read_i pulse → ready low; next event not presented for 16 cycles.
- Simultaneous sources: PS/2 strobe "a" in the same cycle joy bit2 rises → presented order is "a" press, then "3" press. Joy bit2 falls afterward → "3" release follows.
- Fast joystick tap: bit9 high one cycle while FIFO is full → once space frees, "0" press is enqueued before "0" release; overflow_o stays 0.
- Overflow: 5 PS/2 strobes with no ack (depth 4, one already presented) → FIFO holds 4, 6th strobe is dropped, overflow_o=1 and remains 1 until res_n_i low.
- Timeout: present event, never assert rx_read_i → timeout_o pulses exactly at cycle 65535 of PRESENT, ready drops, next entry is presented after the gap.
- Reset mid-PRESENT: assert res_n_i low asynchronously → rx_data_ready_o=0 without a clock edge; after release the FIFO is empty and no stale event appears.
